word_unloader: RTL and testbench

- Reader-side counterpart to the enable-captured parallel register.
- Accepts a parallel DATA_WIDTH word on an enable strobe and buffers up to two words.
- Drains each word bit-serially to a downstream consumer with a valid/ready handshake, and marks the last bit of each word.
- Sits between core output registers (spike/packet words) and narrow serial links or debug readout.

---
 rtl/word_unloader_pkg.sv | 18 +
 rtl/word_shifter.sv | 49 ++++
 rtl/word_unloader.sv | 110 +++++++++++
 tb/tb_word_unloader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_unloader_pkg.sv
// Shared types and helpers for the word unloader: FSM states, bit-order selectors,
// and the bit-counter width function.
package word_unloader_pkg;

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   localparam bit LsbFirst = 1'b0;
   localparam bit MsbFirst = 1'b1;

   // Width of the bit counter; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/word_shifter.sv
// Shift register and bit counter for one word in flight; presents the output-end bit
// and flags the final bit of the word.
module word_shifter
   import word_unloader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = LsbFirst
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift,
   output logic                  out_bit,
   output logic                  at_last
);

   localparam int unsigned     CntW   = cnt_width(DATA_WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sh_q;
   logic [DATA_WIDTH-1:0] sh_shifted;
   logic [CntW-1:0]       cnt_q;

   if (MSB_FIRST == MsbFirst) begin : g_msb
      assign sh_shifted = {sh_q[DATA_WIDTH-2:0], 1'b0};
      assign out_bit    = sh_q[DATA_WIDTH-1];
   end else begin : g_lsb
      assign sh_shifted = {1'b0, sh_q[DATA_WIDTH-1:1]};
      assign out_bit    = sh_q[0];
   end

   assign at_last = (cnt_q == CntMax);

   // A reload wins over a shift; the counter saturates at the last bit until reloaded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sh_q  <= load_data;
         cnt_q <= '0;
      end else if (shift && (cnt_q != CntMax)) begin
         sh_q  <= sh_shifted;
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/word_unloader.sv
// Two-slot parallel-in, bit-serial-out unloader with valid/ready handshake,
// last-bit marking, full flag and overflow pulse.
module word_unloader
   import word_unloader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = LsbFirst
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] d,
   output logic                  full,
   output logic                  overflow,
   output logic                  sout,
   output logic                  sout_valid,
   output logic                  sout_last,
   input  logic                  sout_ready
);

   state_e                state_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  hold_v_q;
   logic                  full_q;
   logic                  overflow_q;

   logic                  active;
   logic                  xfer;
   logic                  last_xfer;
   logic                  sh_load;
   logic [DATA_WIDTH-1:0] sh_load_data;
   logic                  sh_bit;
   logic                  sh_last;

   assign active    = (state_q == StShift);
   assign xfer      = active & sout_ready;
   assign last_xfer = xfer & sh_last;

   // Shift register reloads from idle, or on the final bit when another word is waiting.
   assign sh_load      = (~active & en) | (last_xfer & (hold_v_q | en));
   assign sh_load_data = hold_v_q ? hold_q : d;

   word_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .MSB_FIRST  (MSB_FIRST)
   ) u_shifter (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (sh_load),
      .load_data (sh_load_data),
      .shift     (xfer),
      .out_bit   (sh_bit),
      .at_last   (sh_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         hold_q     <= '0;
         hold_v_q   <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               full_q <= 1'b0;
               if (en) begin
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (last_xfer) begin
                  if (hold_v_q) begin
                     // Held word moves into the shifter; a new word refills the slot.
                     hold_v_q <= en;
                     full_q   <= en;
                     if (en) begin
                        hold_q <= d;
                     end
                  end else begin
                     full_q <= 1'b0;
                     if (!en) begin
                        state_q <= StIdle;
                     end
                  end
               end else if (en) begin
                  full_q <= 1'b1;
                  if (hold_v_q) begin
                     overflow_q <= 1'b1;
                  end else begin
                     hold_q   <= d;
                     hold_v_q <= 1'b1;
                  end
               end else begin
                  full_q <= hold_v_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sout_valid = active;
   assign sout       = active & sh_bit;
   assign sout_last  = active & sh_last;
   assign full       = full_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_word_unloader.sv
// Bench for word_unloader: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a word-queue reference model.
module tb_word_unloader;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         en = 1'b0;
   logic [W-1:0] d = '0;
   logic         sout_ready = 1'b0;

   logic l_full, l_overflow, l_sout, l_sout_valid, l_sout_last;
   logic m_full, m_overflow, m_sout, m_sout_valid, m_sout_last;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending words in arrival order, bit position within the front word.
   logic [W-1:0] mq[$];
   int           mpos = 0;
   logic         m_full_exp = 1'b0;
   logic         m_ovf_exp = 1'b0;

   logic [W-1:0] cap_l = '0;
   logic [W-1:0] cap_m = '0;

   always #5 clk = ~clk;

   word_unloader #(
      .DATA_WIDTH (W),
      .MSB_FIRST  (1'b0)
   ) dut_lsb (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .d          (d),
      .full       (l_full),
      .overflow   (l_overflow),
      .sout       (l_sout),
      .sout_valid (l_sout_valid),
      .sout_last  (l_sout_last),
      .sout_ready (sout_ready)
   );

   word_unloader #(
      .DATA_WIDTH (W),
      .MSB_FIRST  (1'b1)
   ) dut_msb (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .d          (d),
      .full       (m_full),
      .overflow   (m_overflow),
      .sout       (m_sout),
      .sout_valid (m_sout_valid),
      .sout_last  (m_sout_last),
      .sout_ready (sout_ready)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mpos       = 0;
      m_full_exp = 1'b0;
      m_ovf_exp  = 1'b0;
   endtask

   task automatic model_update(input logic e, input logic [W-1:0] dv, input logic r);
      logic dropped;
      dropped = 1'b0;
      if (mq.size() > 0 && r) begin
         if (mpos == W - 1) begin
            void'(mq.pop_front());
            mpos = 0;
         end else begin
            mpos++;
         end
      end
      if (e) begin
         if (mq.size() < 2) mq.push_back(dv);
         else dropped = 1'b1;
      end
      m_full_exp = (mq.size() == 2);
      m_ovf_exp  = dropped;
   endtask

   task automatic check_outputs();
      logic         ev;
      logic         el;
      logic [W-1:0] w;
      ev = (mq.size() > 0);
      w  = ev ? mq[0] : '0;
      el = ev && (mpos == W - 1);
      chk1("lsb.sout_valid", l_sout_valid, ev);
      chk1("lsb.sout", l_sout, ev ? w[mpos] : 1'b0);
      chk1("lsb.sout_last", l_sout_last, el);
      chk1("lsb.full", l_full, m_full_exp);
      chk1("lsb.overflow", l_overflow, m_ovf_exp);
      chk1("msb.sout_valid", m_sout_valid, ev);
      chk1("msb.sout", m_sout, ev ? w[W-1-mpos] : 1'b0);
      chk1("msb.sout_last", m_sout_last, el);
      chk1("msb.full", m_full, m_full_exp);
      chk1("msb.overflow", m_overflow, m_ovf_exp);
   endtask

   task automatic step(input logic e, input logic [W-1:0] dv, input logic r);
      @(negedge clk);
      en         = e;
      d          = dv;
      sout_ready = r;
      check_outputs();
      if (l_sout_valid && r) cap_l = {l_sout, cap_l[W-1:1]};
      if (m_sout_valid && r) cap_m = {cap_m[W-2:0], m_sout};
      @(posedge clk);
      model_update(e, dv, r);
   endtask

   task automatic idle_steps(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, '0, r);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      #1;
      chk1("rst.lsb.sout_valid", l_sout_valid, 1'b0);
      chk1("rst.lsb.sout", l_sout, 1'b0);
      chk1("rst.lsb.sout_last", l_sout_last, 1'b0);
      chk1("rst.lsb.full", l_full, 1'b0);
      chk1("rst.lsb.overflow", l_overflow, 1'b0);
      chk1("rst.msb.sout_valid", m_sout_valid, 1'b0);
      chk1("rst.msb.sout", m_sout, 1'b0);
      chk1("rst.msb.sout_last", m_sout_last, 1'b0);
      chk1("rst.msb.full", m_full, 1'b0);
      chk1("rst.msb.overflow", m_overflow, 1'b0);
      model_reset();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         en = 1'b1;
         d  = W'($urandom);
      end
      @(negedge clk);
      en      = 1'b0;
      reset_n = 1'b1;
   endtask

   initial begin
      #1;
      do_reset(3);

      // Single word
      step(1'b1, 8'hA5, 1'b1);
      idle_steps(9, 1'b1);
      chk8("single.lsb_word", cap_l, 8'hA5);
      chk8("single.msb_word", cap_m, 8'hA5);

      // Backpressure
      step(1'b1, 8'h3C, 1'b1);
      for (int i = 0; i < 18; i++) step(1'b0, '0, (i % 2) == 0);
      chk8("bp.lsb_word", cap_l, 8'h3C);
      chk8("bp.msb_word", cap_m, 8'h3C);

      // Back-to-back
      step(1'b1, 8'hFF, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b1, 8'h00, 1'b1);
      idle_steps(16, 1'b1);
      chk8("b2b.lsb_word", cap_l, 8'h00);

      // Overflow
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      idle_steps(3, 1'b0);
      idle_steps(20, 1'b1);
      chk8("ovf.lsb_word", cap_l, 8'h22);
      chk8("ovf.msb_word", cap_m, 8'h22);

      // Final-bit transfer coincides with a load while the hold slot is occupied
      step(1'b1, 8'h5A, 1'b1);
      step(1'b1, 8'hC3, 1'b1);
      idle_steps(6, 1'b1);
      step(1'b1, 8'h81, 1'b1);
      idle_steps(18, 1'b1);
      chk8("simul.lsb_word", cap_l, 8'h81);
      chk8("simul.msb_word", cap_m, 8'h81);

      // Reset mid-word
      step(1'b1, 8'hC0, 1'b1);
      idle_steps(3, 1'b1);
      #2;
      do_reset(2);
      step(1'b1, 8'h80, 1'b1);
      idle_steps(9, 1'b1);
      chk8("rstmid.msb_word", cap_m, 8'h80);
      chk8("rstmid.lsb_word", cap_l, 8'h80);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 3) != 0);
      end
      idle_steps(24, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
